// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/halt/reset sequencer for a debug-controlled CPU.
// Gates the CPU clock enable for single-step, free-run and reset sequences,
// stops on a PC breakpoint, and counts executed CPU cycles.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (accepted when both high at a rising edge)
//   cmd_op                00 STEP, 01 RUN, 10 HALT, 11 CPU_RESET
//   cmd_cnt               step count for STEP
//   bp_en, bp_addr        breakpoint enable and PC
//   pc                    CPU IF-stage PC (current cycle)
//   cpu_ce, cpu_rst       CPU clock enable and CPU reset
//   busy                  controller not idle
//   done, stop_cause      completion pulse and reason (00 reset, 01 count, 10 bp, 11 halt)
//   cyc_cnt               total CPU cycles executed (reset sequence excluded)
module cpu_run_ctrl #(
  parameter int unsigned RST_HOLD = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             cmd_ready,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  output logic             cpu_ce,
  output logic             cpu_rst,
  output logic             busy,
  output logic             done,
  output logic [1:0]       stop_cause,
  output logic [31:0]      cyc_cnt
);

  localparam int unsigned HW = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD);

  localparam logic [1:0] OP_STEP = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b10;
  localparam logic [1:0] OP_CRST = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RSEQ, S_STEP, S_RUN} state_t;

  state_t           state;
  logic [HW-1:0]    hold;
  logic [CNT_W-1:0] remaining;
  logic             first;

  logic bp_hit;
  logic bp_stop;
  logic accept;
  logic halt_req;

  always_comb begin
    bp_hit    = bp_en && (pc == bp_addr);
    // The breakpoint is only honoured once the command has executed a cycle,
    // so a new command can always step off the PC it stopped on.
    bp_stop   = bp_hit && first;
    cmd_ready = !rst && ((state == S_IDLE) || (state == S_RUN));
    accept    = cmd_valid && cmd_ready;
    halt_req  = accept && (state == S_RUN) && (cmd_op == OP_HALT);
    busy      = rst || (state != S_IDLE);
    cpu_rst   = rst || (state == S_RSEQ);
    cpu_ce    = 1'b0;
    if (!rst) begin
      unique case (state)
        S_RSEQ:  cpu_ce = 1'b1;
        S_STEP:  cpu_ce = !bp_stop;
        S_RUN:   cpu_ce = !bp_stop && !halt_req;
        default: cpu_ce = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RSEQ;
      hold       <= HOLD_INIT;
      cyc_cnt    <= '0;
      stop_cause <= 2'b00;
      done       <= 1'b0;
      remaining  <= '0;
      first      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cpu_ce && (state != S_RSEQ))
        cyc_cnt <= cyc_cnt + 32'd1;

      unique case (state)
        S_IDLE: begin
          if (accept) begin
            unique case (cmd_op)
              OP_STEP: begin
                if (cmd_cnt != '0) begin
                  remaining <= cmd_cnt;
                  first     <= 1'b0;
                  state     <= S_STEP;
                end else begin
                  done       <= 1'b1;
                  stop_cause <= 2'b01;
                end
              end
              OP_RUN: begin
                first <= 1'b0;
                state <= S_RUN;
              end
              OP_HALT: begin
                done       <= 1'b1;
                stop_cause <= 2'b11;
              end
              OP_CRST: begin
                hold  <= HOLD_INIT;
                state <= S_RSEQ;
              end
              default: ;
            endcase
          end
        end

        S_RSEQ: begin
          if (hold <= HW'(1)) begin
            state      <= S_IDLE;
            done       <= 1'b1;
            stop_cause <= 2'b00;
          end else begin
            hold <= hold - HW'(1);
          end
        end

        S_STEP: begin
          if (bp_stop) begin
            state      <= S_IDLE;
            done       <= 1'b1;
            stop_cause <= 2'b10;
          end else begin
            remaining <= remaining - CNT_W'(1);
            first     <= 1'b1;
            if (remaining == CNT_W'(1)) begin
              state      <= S_IDLE;
              done       <= 1'b1;
              stop_cause <= 2'b01;
            end
          end
        end

        S_RUN: begin
          // HALT outranks a simultaneous breakpoint; other ops are dropped.
          if (halt_req) begin
            state      <= S_IDLE;
            done       <= 1'b1;
            stop_cause <= 2'b11;
          end else if (bp_stop) begin
            state      <= S_IDLE;
            done       <= 1'b1;
            stop_cause <= 2'b10;
          end else begin
            first <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: self-checking bench for cpu_run_ctrl. A tiny CPU model
// advances pc by 4 per cpu_ce pulse; expected pulse counts, latencies and
// stop causes are computed from the command rules (breakpoint distance,
// step count) rather than from the controller's internal state.
module tb_cpu_run_ctrl;

  localparam int RST_HOLD = 4;
  localparam int LIMIT    = 300;
  localparam int NEVER    = 1 << 30;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_cnt;
  logic        cmd_ready;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        cpu_ce;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic [1:0]  stop_cause;
  logic [31:0] cyc_cnt;

  logic        pc_load;
  logic [31:0] pc_load_val;

  int checks   = 0;
  int failures = 0;
  int exp_cyc  = 0;

  cpu_run_ctrl #(.RST_HOLD(RST_HOLD), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_cnt(cmd_cnt), .cmd_ready(cmd_ready), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc), .cpu_ce(cpu_ce), .cpu_rst(cpu_rst),
    .busy(busy), .done(done), .stop_cause(stop_cause), .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  // Minimal CPU: reset vector 0x3000, otherwise sequential fetch.
  always @(posedge clk) begin
    if (pc_load)     pc <= pc_load_val;
    else if (cpu_ce) pc <= cpu_rst ? 32'h0000_3000 : pc + 32'd4;
  end

  // Number of pulses before the CPU reaches the breakpoint (never on the start PC).
  function automatic int bp_dist(input logic [31:0] start, input logic en, input logic [31:0] addr);
    logic [31:0] diff;
    diff = addr - start;
    if (!en || diff == 32'd0 || diff[1:0] != 2'b00 || diff > 32'd4000) return NEVER;
    return int'(diff >> 2);
  endfunction

  task automatic load_pc(input logic [31:0] v);
    @(negedge clk);
    pc_load = 1'b1; pc_load_val = v;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  // Issues one command and measures it until done (no checking here).
  task automatic exec_cmd(input logic [1:0] op, input logic [15:0] cnt,
                          output int pulses, output int rpulses, output int cycles,
                          output logic [1:0] cause, output logic rdy,
                          output logic tmo, output logic done_busy);
    pulses = 0; rpulses = 0; cycles = 0; cause = 2'bxx; tmo = 1'b1; done_busy = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt;
    #1 rdy = cmd_ready;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      cycles++;
      if (cpu_ce) pulses++;
      if (cpu_ce && cpu_rst) rpulses++;
      if (done && busy) done_busy = 1'b1;
      if (done) begin
        cause = stop_cause; tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int cycles, pulses;
    logic seen_done;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_cnt = '0;
    bp_en = 1'b0; bp_addr = '0; pc_load = 1'b0; pc_load_val = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({cpu_rst, cpu_ce, cmd_ready, busy, done} !== 5'b10010) begin
      failures++;
      $display("FAIL reset_hold: rst/ce/ready/busy/done=%b want 10010", {cpu_rst, cpu_ce, cmd_ready, busy, done});
    end
    checks++;
    if (cyc_cnt !== 32'd0 || stop_cause !== 2'b00) begin
      failures++;
      $display("FAIL reset_regs: cyc_cnt=%0d cause=%b want 0/00", cyc_cnt, stop_cause);
    end
    @(negedge clk);
    rst = 1'b0;
    cycles = 0; pulses = 0; seen_done = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      #1;
      cycles++;
      if (cpu_ce && cpu_rst) pulses++;
      if (done) begin seen_done = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen_done || pulses != RST_HOLD || cycles != RST_HOLD + 1) begin
      failures++;
      $display("FAIL reset_seq: done=%0b rst_pulses=%0d cycles=%0d want 1/%0d/%0d", seen_done, pulses, cycles, RST_HOLD, RST_HOLD + 1);
    end
    checks++;
    if (stop_cause !== 2'b00 || cmd_ready !== 1'b1 || busy !== 1'b0 || cyc_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_done: cause=%b ready=%b busy=%b cyc=%0d want 00/1/0/0", stop_cause, cmd_ready, busy, cyc_cnt);
    end
    exp_cyc = 0;
  endtask

  task automatic test_step5;
    int p, rp, c; logic [1:0] cs; logic rdy, tmo, db;
    bp_en = 1'b0;
    exec_cmd(2'b00, 16'd5, p, rp, c, cs, rdy, tmo, db);
    exp_cyc += 5;
    checks++;
    if (tmo || !rdy || db || p != 5 || c != 6 || cs !== 2'b01) begin
      failures++;
      $display("FAIL step5: tmo=%0b rdy=%0b db=%0b pulses=%0d cycles=%0d cause=%b want 0/1/0/5/6/01", tmo, rdy, db, p, c, cs);
    end
    checks++;
    if (cyc_cnt !== 32'(exp_cyc)) begin
      failures++;
      $display("FAIL step5_cyc: cyc_cnt=%0d want %0d", cyc_cnt, exp_cyc);
    end
    @(negedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL step5_done_width: done=%b want 0", done);
    end
  endtask

  task automatic test_breakpoint;
    int p, rp, c; logic [1:0] cs; logic rdy, tmo, db;
    load_pc(32'h0000_3000);
    bp_en = 1'b1; bp_addr = 32'h0000_3010;
    exec_cmd(2'b01, 16'd0, p, rp, c, cs, rdy, tmo, db);
    exp_cyc += 4;
    checks++;
    if (tmo || !rdy || db || p != 4 || c != 6 || cs !== 2'b10 || pc !== 32'h0000_3010) begin
      failures++;
      $display("FAIL run_bp: tmo=%0b pulses=%0d cycles=%0d cause=%b pc=%h want 0/4/6/10/3010", tmo, p, c, cs, pc);
    end
    exec_cmd(2'b00, 16'd1, p, rp, c, cs, rdy, tmo, db);
    exp_cyc += 1;
    checks++;
    if (tmo || !rdy || db || p != 1 || c != 2 || cs !== 2'b01) begin
      failures++;
      $display("FAIL step_off_bp: tmo=%0b pulses=%0d cycles=%0d cause=%b want 0/1/2/01", tmo, p, c, cs);
    end
    checks++;
    if (cyc_cnt !== 32'(exp_cyc)) begin
      failures++;
      $display("FAIL bp_cyc: cyc_cnt=%0d want %0d", cyc_cnt, exp_cyc);
    end
    bp_en = 1'b0;
  endtask

  task automatic test_halt;
    int p;
    logic step_rdy, ce_halt, halt_rdy;
    load_pc(32'h0000_5000);
    bp_en = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_cnt = '0;
    p = 0; step_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cmd_valid = (i == 4); cmd_op = 2'b00; cmd_cnt = 16'd3;
      #1;
      if (i == 4) step_rdy = cmd_ready;
      if (cpu_ce) p++;
    end
    @(negedge clk);
    bp_en = 1'b1; bp_addr = pc;
    cmd_valid = 1'b1; cmd_op = 2'b10;
    #1 ce_halt = cpu_ce; halt_rdy = cmd_ready;
    exp_cyc += 10;
    checks++;
    if (p != 10 || !step_rdy) begin
      failures++;
      $display("FAIL run_pulses: pulses=%0d step_ready=%0b want 10/1", p, step_rdy);
    end
    checks++;
    if (ce_halt !== 1'b0 || halt_rdy !== 1'b1) begin
      failures++;
      $display("FAIL halt_cycle: cpu_ce=%b ready=%b want 0/1", ce_halt, halt_rdy);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || stop_cause !== 2'b11 || cyc_cnt !== 32'(exp_cyc)) begin
      failures++;
      $display("FAIL halt_done: done=%b busy=%b cause=%b cyc=%0d want 1/0/11/%0d", done, busy, stop_cause, cyc_cnt, exp_cyc);
    end
    @(negedge clk); #1;
    checks++;
    if (done !== 1'b0 || cpu_ce !== 1'b0) begin
      failures++;
      $display("FAIL halt_after: done=%b cpu_ce=%b want 0/0", done, cpu_ce);
    end
    bp_en = 1'b0;
  endtask

  task automatic test_zero_and_idle_halt;
    int p, rp, c; logic [1:0] cs; logic rdy, tmo, db;
    exec_cmd(2'b00, 16'd0, p, rp, c, cs, rdy, tmo, db);
    checks++;
    if (tmo || !rdy || db || p != 0 || c != 1 || cs !== 2'b01) begin
      failures++;
      $display("FAIL step0: tmo=%0b pulses=%0d cycles=%0d cause=%b want 0/0/1/01", tmo, p, c, cs);
    end
    exec_cmd(2'b10, 16'd7, p, rp, c, cs, rdy, tmo, db);
    checks++;
    if (tmo || !rdy || db || p != 0 || c != 1 || cs !== 2'b11) begin
      failures++;
      $display("FAIL idle_halt: tmo=%0b pulses=%0d cycles=%0d cause=%b want 0/0/1/11", tmo, p, c, cs);
    end
  endtask

  task automatic test_random;
    int p, rp, c; logic [1:0] cs; logic rdy, tmo, db;
    int r, k, n, ep, ec; logic [1:0] ecs, op;
    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(0, 9));
      bp_en   = 1'($urandom_range(0, 1));
      bp_addr = pc + 32'(4 * $urandom_range(0, 12)) + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      n = 0;
      if (r <= 4)      begin op = 2'b00; n = int'($urandom_range(1, 12)); end
      else if (r <= 6) begin op = 2'b01; bp_en = 1'b1; bp_addr = pc + 32'(4 * $urandom_range(1, 12)); end
      else if (r == 7) op = 2'b10;
      else if (r == 8) op = 2'b11;
      else             op = 2'b00;
      k = bp_dist(pc, bp_en, bp_addr);
      case (op)
        2'b00: if (n == 0) begin ep = 0; ec = 1; ecs = 2'b01; end
               else if (k < n) begin ep = k; ec = k + 2; ecs = 2'b10; end
               else begin ep = n; ec = n + 1; ecs = 2'b01; end
        2'b01: begin ep = k; ec = k + 2; ecs = 2'b10; end
        2'b10: begin ep = 0; ec = 1; ecs = 2'b11; end
        default: begin ep = RST_HOLD; ec = RST_HOLD + 1; ecs = 2'b00; end
      endcase
      exec_cmd(op, 16'(n), p, rp, c, cs, rdy, tmo, db);
      if (op != 2'b11) exp_cyc += ep;
      checks++;
      if (tmo || !rdy || db || p != ep || c != ec || cs !== ecs) begin
        failures++;
        $display("FAIL rand[%0d] op=%b n=%0d: tmo=%0b rdy=%0b db=%0b pulses=%0d cycles=%0d cause=%b want 0/1/0/%0d/%0d/%b",
                 it, op, n, tmo, rdy, db, p, c, cs, ep, ec, ecs);
      end
      checks++;
      if (cyc_cnt !== 32'(exp_cyc) || (op == 2'b11 && rp != RST_HOLD)) begin
        failures++;
        $display("FAIL rand_cyc[%0d]: cyc_cnt=%0d rst_pulses=%0d want %0d", it, cyc_cnt, rp, exp_cyc);
      end
    end
    bp_en = 1'b0;
  endtask

  task automatic test_rst_mid_step;
    int p, cycles, rp;
    logic early_done, seen_done;
    logic [31:0] cyc_before;
    bp_en = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_cnt = 16'd100;
    p = 0; early_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      if (cpu_ce) p++;
      if (done) early_done = 1'b1;
    end
    @(negedge clk);
    cyc_before = cyc_cnt;
    rst = 1'b1;
    #1;
    if (cpu_ce) p++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      if (done || cpu_ce) early_done = 1'b1;
    end
    checks++;
    if (p != 20 || cyc_before !== 32'(exp_cyc + 20) || early_done) begin
      failures++;
      $display("FAIL rst_mid_pre: pulses=%0d cyc=%0d stray=%0b want 20/%0d/0", p, cyc_before, early_done, exp_cyc + 20);
    end
    @(negedge clk);
    rst = 1'b0;
    cycles = 0; rp = 0; seen_done = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      #1;
      cycles++;
      if (cpu_ce && cpu_rst) rp++;
      if (done) begin seen_done = 1'b1; break; end
      @(negedge clk);
    end
    exp_cyc = 0;
    checks++;
    if (!seen_done || rp != RST_HOLD || cycles != RST_HOLD + 1 || stop_cause !== 2'b00 || cyc_cnt !== 32'd0) begin
      failures++;
      $display("FAIL rst_mid_post: done=%0b rst_pulses=%0d cycles=%0d cause=%b cyc=%0d want 1/%0d/%0d/00/0",
               seen_done, rp, cycles, stop_cause, cyc_cnt, RST_HOLD, RST_HOLD + 1);
    end
  endtask

  initial begin
    test_reset();
    test_step5();
    test_breakpoint();
    test_halt();
    test_zero_and_idle_halt();
    test_random();
    test_rst_mid_step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
